// File: rtl/scan_chain_ctrl.sv
// Scan chain test controller: shifts a parallel pattern into a scan-set chain,
// optionally pulses one functional capture cycle, then unloads the chain into RESULT.
module scan_chain_ctrl #(
   parameter int CHAIN_LEN = 16,
   localparam int CNT_W = $clog2(CHAIN_LEN + 1)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic                 CAPTURE_EN,
   input  logic [CHAIN_LEN-1:0] PAT,
   input  logic                 PRESET,
   input  logic                 SO,
   output logic                 TE,
   output logic                 TI,
   output logic                 S_OUT,
   output logic                 BUSY,
   output logic                 DONE,
   output logic [CHAIN_LEN-1:0] RESULT
);

   typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, UNLOAD, FIN} state_t;

   state_t               state;
   state_t               state_next;
   logic [CNT_W-1:0]     cnt;
   logic [CHAIN_LEN-1:0] pat_q;
   logic [CHAIN_LEN-1:0] res_q;
   logic [CHAIN_LEN-1:0] result_q;
   logic [CHAIN_LEN-1:0] res_shift;
   logic                 cap_en_q;
   logic                 s_out_q;
   logic                 last_bit;

   assign last_bit  = (cnt == CNT_W'(CHAIN_LEN - 1));
   assign res_shift = (res_q << 1) | CHAIN_LEN'(SO);
   assign S_OUT     = s_out_q;
   assign RESULT    = result_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Outputs depend only on state and the pattern register, never on inputs.
   always_comb begin
      state_next = state;
      TE         = 1'b0;
      TI         = 1'b0;
      BUSY       = 1'b0;
      DONE       = 1'b0;
      case (state)
         IDLE: begin
            if (START) state_next = SHIFT;
         end
         SHIFT: begin
            TE   = 1'b1;
            TI   = pat_q[CHAIN_LEN-1];
            BUSY = 1'b1;
            if (last_bit) state_next = cap_en_q ? CAPTURE : UNLOAD;
         end
         CAPTURE: begin
            BUSY       = 1'b1;
            state_next = UNLOAD;
         end
         UNLOAD: begin
            TE   = 1'b1;
            BUSY = 1'b1;
            if (last_bit) state_next = FIN;
         end
         FIN: begin
            DONE       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The pattern register shifts left so its MSB is always the next bit to send.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt      <= '0;
         pat_q    <= '0;
         res_q    <= '0;
         result_q <= '0;
         cap_en_q <= 1'b0;
         s_out_q  <= 1'b0;
      end else begin
         s_out_q <= (state == IDLE) && PRESET && !START;
         case (state)
            IDLE: begin
               if (START) begin
                  pat_q    <= PAT;
                  cap_en_q <= CAPTURE_EN;
                  cnt      <= '0;
               end
            end
            SHIFT: begin
               pat_q <= pat_q << 1;
               cnt   <= last_bit ? '0 : cnt + CNT_W'(1);
            end
            CAPTURE: begin
               cnt <= '0;
            end
            UNLOAD: begin
               res_q <= res_shift;
               cnt   <= last_bit ? '0 : cnt + CNT_W'(1);
               if (last_bit) result_q <= res_shift;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: behavioural scan-set chains (16 cells and 1 cell) around
// two controller instances, with expected timing and results derived from cycle arithmetic.
module tb_scan_chain_ctrl;

   localparam int N = 16;

   logic         CLK = 1'b0;
   logic         RST;
   logic         START, CAPTURE_EN, PRESET;
   logic [N-1:0] PAT;
   logic         TE, TI, S_OUT, BUSY, DONE;
   logic [N-1:0] RESULT;
   logic [N-1:0] chain = '0;
   logic [N-1:0] d_func;
   logic         SO;

   logic         start_1, cap_1, preset_1;
   logic [0:0]   pat_1;
   logic         te_1, ti_1, s_out_1, busy_1, done_1;
   logic [0:0]   result_1;
   logic         chain_1 = 1'b0;
   logic         d_1;

   int           total = 0;
   int           bad = 0;
   logic [N-1:0] prev_result;
   logic         prev_result_1;

   always #5 CLK = ~CLK;

   assign SO = chain[N-1];

   // Scan-with-set cells: set wins, then scan shift, otherwise functional load.
   always @(posedge CLK) begin
      if (S_OUT)   chain <= '1;
      else if (TE) chain <= {chain[N-2:0], TI};
      else         chain <= d_func;
      if (s_out_1)   chain_1 <= 1'b1;
      else if (te_1) chain_1 <= ti_1;
      else           chain_1 <= d_1;
   end

   scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
      .CLK(CLK), .RST(RST), .START(START), .CAPTURE_EN(CAPTURE_EN), .PAT(PAT),
      .PRESET(PRESET), .SO(SO), .TE(TE), .TI(TI), .S_OUT(S_OUT), .BUSY(BUSY),
      .DONE(DONE), .RESULT(RESULT)
   );

   scan_chain_ctrl #(.CHAIN_LEN(1)) dut_1 (
      .CLK(CLK), .RST(RST), .START(start_1), .CAPTURE_EN(cap_1), .PAT(pat_1),
      .PRESET(preset_1), .SO(chain_1), .TE(te_1), .TI(ti_1), .S_OUT(s_out_1), .BUSY(busy_1),
      .DONE(done_1), .RESULT(result_1)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // One full sequence on the 16-cell instance, checked every cycle; ends one cycle into IDLE.
   task automatic applyStimulus(input logic [N-1:0] pat, input logic cap, input logic [N-1:0] dval,
                                input bit disturb, input bit preset_too);
      int           done_k;
      logic [N-1:0] exp_res;
      logic         exp_te;
      done_k     = cap ? 2*N + 2 : 2*N + 1;
      exp_res    = cap ? dval : pat;
      PAT        = pat;
      CAPTURE_EN = cap;
      d_func     = dval;
      PRESET     = preset_too;
      START      = 1'b1;
      for (int k = 1; k <= done_k; k++) begin
         step();
         START  = 1'b0;
         PRESET = 1'b0;
         exp_te = (k <= N) || (cap ? (k >= N + 2 && k <= 2*N + 1) : (k >= N + 1 && k <= 2*N));
         checkOutput("te", 32'(TE), 32'(exp_te));
         checkOutput("busy", 32'(BUSY), 32'(k < done_k));
         checkOutput("done", 32'(DONE), 32'(k == done_k));
         checkOutput("s_out_busy", 32'(S_OUT), 32'(0));
         if (k <= N)
            checkOutput("ti_shift", 32'(TI), 32'(pat[N-k]));
         else if (k < done_k)
            checkOutput("ti_idle", 32'(TI), 32'(0));
         checkOutput("result", 32'(RESULT), 32'((k == done_k) ? exp_res : prev_result));
         if (disturb && k < done_k) begin
            if (k == 3) PAT = '0;
            if (k == 5 || k == 20) START = 1'b1;
            if (k == 10) PRESET = 1'b1;
            if ($urandom_range(0, 7) == 0) START = 1'b1;
            if ($urandom_range(0, 7) == 0) PRESET = 1'b1;
            if ($urandom_range(0, 3) == 0) PAT = N'($urandom);
            CAPTURE_EN = 1'($urandom);
         end
      end
      prev_result = exp_res;
      step();
      checkOutput("idle_te", 32'(TE), 32'(0));
      checkOutput("idle_busy", 32'(BUSY), 32'(0));
      checkOutput("idle_done", 32'(DONE), 32'(0));
      checkOutput("idle_result", 32'(RESULT), 32'(exp_res));
   endtask

   // Same idea for the single-cell instance.
   task automatic applyStimulusOne(input logic pat, input logic cap, input logic dval);
      int   done_k;
      logic exp_res;
      done_k  = cap ? 4 : 3;
      exp_res = cap ? dval : pat;
      pat_1   = pat;
      cap_1   = cap;
      d_1     = dval;
      start_1 = 1'b1;
      for (int k = 1; k <= done_k; k++) begin
         step();
         start_1 = 1'b0;
         checkOutput("te_1", 32'(te_1), 32'((k == 1) || (cap ? k == 3 : k == 2)));
         checkOutput("busy_1", 32'(busy_1), 32'(k < done_k));
         checkOutput("done_1", 32'(done_1), 32'(k == done_k));
         checkOutput("result_1", 32'(result_1), 32'((k == done_k) ? exp_res : prev_result_1));
      end
      prev_result_1 = exp_res;
      step();
   endtask

   initial begin
      RST = 1'b1; START = 1'b0; CAPTURE_EN = 1'b0; PRESET = 1'b0; PAT = '0; d_func = '0;
      start_1 = 1'b0; cap_1 = 1'b0; preset_1 = 1'b0; pat_1 = '0; d_1 = 1'b0;
      prev_result = '0;
      prev_result_1 = 1'b0;
      step();
      step();
      checkOutput("rst_te", 32'(TE), 32'(0));
      checkOutput("rst_ti", 32'(TI), 32'(0));
      checkOutput("rst_busy", 32'(BUSY), 32'(0));
      checkOutput("rst_done", 32'(DONE), 32'(0));
      checkOutput("rst_s_out", 32'(S_OUT), 32'(0));
      checkOutput("rst_result", 32'(RESULT), 32'(0));
      checkOutput("rst_result_1", 32'(result_1), 32'(0));
      RST = 1'b0;
      step();

      $display("[TB] integrity and capture runs");
      applyStimulus(16'hA5C3, 1'b0, N'($urandom), 1'b0, 1'b0);
      applyStimulus(16'hFFFF, 1'b1, 16'h1234, 1'b0, 1'b0);

      $display("[TB] busy protection");
      applyStimulus(16'h8001, 1'b0, N'($urandom), 1'b1, 1'b0);

      $display("[TB] mid-sequence reset");
      PAT = 16'h1234; CAPTURE_EN = 1'b0; START = 1'b1;
      step();
      START = 1'b0;
      for (int i = 0; i < 9; i++) step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      checkOutput("mrst_te", 32'(TE), 32'(0));
      checkOutput("mrst_ti", 32'(TI), 32'(0));
      checkOutput("mrst_busy", 32'(BUSY), 32'(0));
      checkOutput("mrst_done", 32'(DONE), 32'(0));
      checkOutput("mrst_result", 32'(RESULT), 32'(0));
      prev_result = '0;
      applyStimulus(16'h00FF, 1'b0, N'($urandom), 1'b0, 1'b0);

      $display("[TB] preset");
      d_func = 16'h0000;
      PRESET = 1'b1;
      step();
      PRESET = 1'b0;
      checkOutput("preset_pulse", 32'(S_OUT), 32'(1));
      step();
      checkOutput("preset_end", 32'(S_OUT), 32'(0));
      checkOutput("preset_chain", 32'(chain), 32'(16'hFFFF));
      applyStimulus(N'($urandom), 1'b1, 16'h0000, 1'b0, 1'b0);
      applyStimulus(N'($urandom), 1'($urandom), N'($urandom), 1'b0, 1'b1);

      $display("[TB] randomized sequences");
      for (int i = 0; i < 6; i++)
         applyStimulus(N'($urandom), 1'($urandom), N'($urandom), 1'($urandom), 1'($urandom));

      $display("[TB] single-cell chain");
      applyStimulusOne(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++)
         applyStimulusOne(1'($urandom), 1'($urandom), 1'($urandom));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Test controller sitting directly upstream and downstream of a chain of scan-with-set flip-flops.
- Upstream role: drives the chain's shared TE and serial TI, plus a preset pulse for the cells' S input.
- Downstream role: consumes the serial output (Q of the last cell).
- Loads a parallel pattern, optionally performs one functional capture cycle, then unloads the chain into a parallel RESULT register.

Parameters:
- CHAIN_LEN, 16, number of scan cells in the chain (>=1); cell 0 is fed by TI, cell CHAIN_LEN-1 drives SO.
- CNT_W, derived as $clog2(CHAIN_LEN+1), width of the internal shift counter; not user-set.

Ports:
- CLK  input  1  single rising-edge clock, shared with the scan chain.
- RST  input  1  synchronous, active-high reset.
- START  input  1  begin a test sequence; sampled only in IDLE.
- CAPTURE_EN  input  1  1 = insert a capture cycle; 0 = chain-integrity (shift-through) run. Sampled with START.
- PAT  input  CHAIN_LEN  pattern to load; PAT[k] ends in cell k. Sampled with START.
- PRESET  input  1  request to set all cells to 1; sampled only in IDLE.
- SO  input  1  serial output of the last chain cell.
- TE  output  1  scan enable to all cells.
- TI  output  1  serial data into cell 0.
- S_OUT  output  1  set request to all cells' S inputs.
- BUSY  output  1  sequence in progress.
- DONE  output  1  one-cycle pulse; RESULT is valid.
- RESULT  output  CHAIN_LEN  unloaded chain contents; RESULT[k] = cell k.

Behaviour:
- Reset (RST=1 at an edge) applies on the next cycle, including mid-sequence:
  - state=IDLE, counter=0, pattern/result registers=0.
  - TE=0, TI=0, S_OUT=0, BUSY=0, DONE=0, RESULT=0.
- States: IDLE, SHIFT, CAPTURE, UNLOAD, FIN.
- All outputs are decoded from registers only; there is no combinational path from any input to any output.
- IDLE (TE=0, TI=0, BUSY=0):
  - START=1 at an edge: latch PAT and CAPTURE_EN, counter=0, go to SHIFT.
  - PRESET=1 with START=0: S_OUT=1 for exactly the next cycle.
  - PRESET and START both high: START wins and PRESET is dropped.
- SHIFT, CHAIN_LEN cycles (TE=1, BUSY=1):
  - TI = pat[CHAIN_LEN-1-cnt], so MSB is shifted first; counter increments each cycle.
  - On the last cycle, go to CAPTURE if the latched CAPTURE_EN=1, else to UNLOAD.
- CAPTURE, 1 cycle (TE=0, TI=0, BUSY=1): the cells load their functional D inputs at the closing edge; then go to UNLOAD with counter=0.
- UNLOAD, CHAIN_LEN cycles (TE=1, TI=0, BUSY=1):
  - At each edge, res <= {res[CHAIN_LEN-2:0], SO}; for CHAIN_LEN=1, res <= SO.
  - After the final edge, go to FIN.
- FIN, 1 cycle: DONE=1, BUSY=0, TE=0; return to IDLE.
- RESULT is updated from res only on entry to FIN. It holds until the next FIN or reset.
- Latency, with START sampled at edge 0:
  - SHIFT occupies cycles 1..N.
  - With capture: CAPTURE is cycle N+1, UNLOAD is N+2..2N+1, DONE is in cycle 2N+2.
  - Without capture: DONE is in cycle 2N+1.
- Inputs ignored while not in IDLE: START, PRESET, and changes to PAT/CAPTURE_EN. S_OUT is never asserted outside IDLE.
- Chain contents after UNLOAD are all zero (TI=0); the controller makes no other guarantee about chain state.

Test Plan:
- Integrity run: bench chain of 16 scan-set cells, CAPTURE_EN=0, PAT=16'hA5C3, START pulse -> TE=1 for cycles 1..32, DONE in cycle 33 only, RESULT=16'hA5C3, BUSY low in cycle 33.
- Capture run: CAPTURE_EN=1, PAT=16'hFFFF, cell D inputs=16'h1234 -> TE=0 in cycle 17 only, DONE in cycle 34, RESULT=16'h1234.
- Busy protection: START re-asserted in cycles 5 and 20, PAT changed to 16'h0000 in cycle 3 (original PAT=16'h8001, CAPTURE_EN=0), PRESET held high in cycle 10 -> exactly one DONE in cycle 33, RESULT=16'h8001, S_OUT never high.
- Mid-sequence reset: RST=1 at cycle 10 of SHIFT -> next cycle TE=0, TI=0, BUSY=0, DONE=0, RESULT=0; a fresh START with PAT=16'h00FF, CAPTURE_EN=0 gives RESULT=16'h00FF.
- Preset: PRESET pulse in IDLE -> S_OUT=1 for one cycle, all chain Q=1. Then START with CAPTURE_EN=1, D=16'h0000 -> RESULT=16'h0000. PRESET and START high in the same cycle -> S_OUT stays 0 and the sequence starts.
- Boundary CHAIN_LEN=1: PAT=1'b1, CAPTURE_EN=0 -> TE high in cycles 1..2, DONE in cycle 3, RESULT=1'b1; repeated back-to-back STARTs (START in the cycle after DONE) are accepted.
